frb_trigger: RTL

//  Threshold trigger placed after the dedispersion/integration stage. Consumes one integrated dedispersed power per frame.

---
 rtl/frb_trigger.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/frb_trigger.sv
// Threshold trigger with a moving-average baseline and frame timestamps.
// Optional build macro PEAK_TRACK_EN reports the peak frame of an event instead of its first frame.
module frb_trigger #(
  parameter int DIN_WIDTH  = 32,
  parameter int AVG_POW    = 4,
  parameter int TS_WIDTH   = 48,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic [DIN_WIDTH-1:0]  thresh,
  input  logic [HOLD_WIDTH-1:0] holdoff,
  output logic                  det_valid,
  output logic [TS_WIDTH-1:0]   det_ts,
  output logic [DIN_WIDTH-1:0]  det_peak,
  output logic [DIN_WIDTH-1:0]  det_baseline,
  output logic [15:0]           det_count,
  output logic                  armed
);

  localparam int SUM_W = DIN_WIDTH + AVG_POW;
  localparam int DEPTH = 1 << AVG_POW;

  typedef enum logic [1:0] {WARMUP, ARMED, HOLDOFF, EVENT} state_t;

  state_t                 state, state_n;
  logic [TS_WIDTH-1:0]    ts;
  logic [SUM_W-1:0]       sum;
  logic [AVG_POW-1:0]     wp;
  logic [HOLD_WIDTH-1:0]  hcnt, hcnt_n;
  logic [DIN_WIDTH-1:0]   ring [DEPTH];
  logic [DIN_WIDTH-1:0]   peak, peak_n;
  logic [TS_WIDTH-1:0]    pts, pts_n;

  logic                   frame, cmp, accum, emit;
  logic [DIN_WIDTH-1:0]   baseline, old, emit_peak;
  logic [TS_WIDTH-1:0]    emit_ts;

  logic                   vld_p1;
  logic [TS_WIDTH-1:0]    ts_p1;
  logic [DIN_WIDTH-1:0]   peak_p1, base_p1;

  assign frame    = ce & din_valid;
  assign baseline = sum[SUM_W-1:AVG_POW];
  // During warmup the ring holds stale data from before reset, so nothing is subtracted.
  assign old      = (state == WARMUP) ? '0 : ring[wp];
  assign cmp      = {1'b0, din} > ({1'b0, baseline} + {1'b0, thresh});

  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    peak_n    = peak;
    pts_n     = pts;
    accum     = 1'b0;
    emit      = 1'b0;
    emit_ts   = ts;
    emit_peak = din;
    if (frame) begin
      case (state)
        WARMUP: begin
          accum = 1'b1;
          if (wp == AVG_POW'(DEPTH - 1)) state_n = ARMED;
        end
        ARMED: begin
          if (cmp) begin
`ifdef PEAK_TRACK_EN
            state_n = EVENT;
            peak_n  = din;
            pts_n   = ts;
`else
            emit = 1'b1;
            if (holdoff != '0) begin
              state_n = HOLDOFF;
              hcnt_n  = holdoff;
            end
`endif
          end else begin
            accum = 1'b1;
          end
        end
        HOLDOFF: begin
          if (hcnt == HOLD_WIDTH'(1)) state_n = ARMED;
          else                        hcnt_n  = hcnt - HOLD_WIDTH'(1);
        end
        EVENT: begin
`ifdef PEAK_TRACK_EN
          if (cmp) begin
            if (din > peak) begin
              peak_n = din;
              pts_n  = ts;
            end
          end else begin
            emit      = 1'b1;
            emit_ts   = pts;
            emit_peak = peak;
            if (holdoff != '0) begin
              state_n = HOLDOFF;
              hcnt_n  = holdoff;
            end else begin
              state_n = ARMED;
            end
          end
`else
          state_n = WARMUP;
`endif
        end
        default: state_n = WARMUP;
      endcase
    end
  end

  // Control state, stage 1 valid, stage 2 outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WARMUP;
      ts           <= '0;
      sum          <= '0;
      wp           <= '0;
      hcnt         <= '0;
      vld_p1       <= 1'b0;
      det_valid    <= 1'b0;
      det_ts       <= '0;
      det_peak     <= '0;
      det_baseline <= '0;
      det_count    <= '0;
      armed        <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      hcnt  <= hcnt_n;
      if (frame) ts <= ts + TS_WIDTH'(1);
      if (accum) begin
        sum <= sum + SUM_W'(din) - SUM_W'(old);
        wp  <= wp + AVG_POW'(1);
      end
      vld_p1    <= emit;
      det_valid <= vld_p1;
      if (vld_p1) begin
        det_ts       <= ts_p1;
        det_peak     <= peak_p1;
        det_baseline <= base_p1;
        if (det_count != 16'hFFFF) det_count <= det_count + 16'd1;
      end
      armed <= (state == ARMED);
    end
  end

  // Data path: ring buffer, peak tracker, stage 1 event capture
  always_ff @(posedge clk) begin
    if (ce) begin
      if (accum) ring[wp] <= din;
      peak <= peak_n;
      pts  <= pts_n;
      if (emit) begin
        ts_p1   <= emit_ts;
        peak_p1 <= emit_peak;
        base_p1 <= baseline;
      end
    end
  end

endmodule
